// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single 8x8 register-file write port between two writeback
// requesters: port A (ALU writeback) and port B (load writeback). Each port
// has a one-entry holding buffer behind a valid/ready handshake. An
// oldest-first, round-robin arbiter drains the buffers into a registered
// write stage. A pending-write mask is exported for decode-stage hazard logic.
//
// Ports
//   Clk            system clock, rising edge
//   Reset          synchronous, active-high reset
//   A_Valid        port A presents a write
//   A_Reg_Num[2:0] port A destination register
//   A_Data[7:0]    port A write data
//   A_Ready        port A transfer when A_Valid && A_Ready
//   B_Valid        port B presents a write
//   B_Reg_Num[2:0] port B destination register
//   B_Data[7:0]    port B write data
//   B_Ready        port B transfer when B_Valid && B_Ready
//   RegWrite       registered write enable to the register file
//   Write_Reg_Num  registered destination register
//   Write_Data     registered write data
//   Busy_Mask[7:0] bit r set while a write to r is buffered or in the write stage

module regfile_write_arbiter (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       A_Valid,
    input  logic [2:0] A_Reg_Num,
    input  logic [7:0] A_Data,
    output logic       A_Ready,
    input  logic       B_Valid,
    input  logic [2:0] B_Reg_Num,
    input  logic [7:0] B_Data,
    output logic       B_Ready,
    output logic       RegWrite,
    output logic [2:0] Write_Reg_Num,
    output logic [7:0] Write_Data,
    output logic [7:0] Busy_Mask
);

    logic       hold_a_valid;
    logic [2:0] hold_a_reg;
    logic [7:0] hold_a_data;
    logic       hold_a_age;

    logic       hold_b_valid;
    logic [2:0] hold_b_reg;
    logic [7:0] hold_b_data;
    logic       hold_b_age;

    logic       rr_ptr;

    logic       grant_a;
    logic       grant_b;
    logic       rr_flip;
    logic       accept_a;
    logic       accept_b;

    // Age=1 marks the younger entry. Both ages set at once cannot occur:
    // an entry only gets age=1 while the other sits ungranted, and any grant
    // clears the survivor's age.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        rr_flip = 1'b0;
        if (hold_a_valid && hold_b_valid) begin
            if (hold_a_age != hold_b_age) begin
                grant_a = !hold_a_age;
                grant_b = hold_a_age;
            end else if (hold_a_reg == hold_b_reg) begin
                // Same-cycle writes to one register: A lands first, B last.
                grant_a = 1'b1;
            end else begin
                rr_flip = 1'b1;
                if (rr_ptr) begin
                    grant_b = 1'b1;
                end else begin
                    grant_a = 1'b1;
                end
            end
        end else begin
            grant_a = hold_a_valid;
            grant_b = hold_b_valid;
        end
    end

    assign A_Ready  = !Reset && (!hold_a_valid || grant_a);
    assign B_Ready  = !Reset && (!hold_b_valid || grant_b);
    assign accept_a = A_Valid && A_Ready;
    assign accept_b = B_Valid && B_Ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hold_a_valid  <= 1'b0;
            hold_a_reg    <= '0;
            hold_a_data   <= '0;
            hold_a_age    <= 1'b0;
            hold_b_valid  <= 1'b0;
            hold_b_reg    <= '0;
            hold_b_data   <= '0;
            hold_b_age    <= 1'b0;
            rr_ptr        <= 1'b0;
            RegWrite      <= 1'b0;
            Write_Reg_Num <= '0;
            Write_Data    <= '0;
        end else begin
            if (accept_a) begin
                hold_a_valid <= 1'b1;
                hold_a_reg   <= A_Reg_Num;
                hold_a_data  <= A_Data;
                hold_a_age   <= hold_b_valid && !grant_b;
            end else begin
                if (grant_a) begin
                    hold_a_valid <= 1'b0;
                end
                if (grant_a || grant_b) begin
                    hold_a_age <= 1'b0;
                end
            end

            if (accept_b) begin
                hold_b_valid <= 1'b1;
                hold_b_reg   <= B_Reg_Num;
                hold_b_data  <= B_Data;
                hold_b_age   <= hold_a_valid && !grant_a;
            end else begin
                if (grant_b) begin
                    hold_b_valid <= 1'b0;
                end
                if (grant_a || grant_b) begin
                    hold_b_age <= 1'b0;
                end
            end

            // After a round-robin decision the loser is favoured next time.
            if (rr_flip) begin
                rr_ptr <= grant_a;
            end

            RegWrite <= grant_a || grant_b;
            if (grant_a) begin
                Write_Reg_Num <= hold_a_reg;
                Write_Data    <= hold_a_data;
            end else if (grant_b) begin
                Write_Reg_Num <= hold_b_reg;
                Write_Data    <= hold_b_data;
            end
        end
    end

    always_comb begin
        Busy_Mask = '0;
        if (hold_a_valid) begin
            Busy_Mask[hold_a_reg] = 1'b1;
        end
        if (hold_b_valid) begin
            Busy_Mask[hold_b_reg] = 1'b1;
        end
        if (RegWrite) begin
            Busy_Mask[Write_Reg_Num] = 1'b1;
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port (Write_Reg_Num / Write_Data / RegWrite) between two writeback requesters: port A (ALU writeback) and port B (load writeback). Each port has a one-entry holding buffer with a valid/ready handshake. An oldest-first, round-robin arbiter drains the buffers into a registered write stage that drives the 8x8 register file directly. A pending-write mask is exported for hazard/stall logic in the decode stage.

## Interface
- No parameters: the width is fixed at 8 data bits and 3 register-number bits, matching the 8x8 register file.
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- A_Valid  in  1  port A presents a write this cycle
- A_Reg_Num  in  3  port A destination register
- A_Data  in  8  port A write data
- A_Ready  out  1  port A transfer occurs when A_Valid && A_Ready
- B_Valid  in  1  port B presents a write this cycle
- B_Reg_Num  in  3  port B destination register
- B_Data  in  8  port B write data
- B_Ready  out  1  port B handshake, same rule as port A
- RegWrite  out  1  registered write enable to the register file
- Write_Reg_Num  out  3  registered destination to the register file
- Write_Data  out  8  registered data to the register file
- Busy_Mask  out  8  bit r=1 if any write to register r is buffered or is in the write stage

## Operation
- Per-port state: Hold_Valid, Hold_Reg (3b), Hold_Data (8b), Hold_Age (1b).
- Global state: RR_Ptr (0=A favoured, 1=B favoured).
- Ready rule (combinational):
  - A_Ready = !Reset && (!HoldA_Valid || Grant_A).
  - B_Ready is the same with B.
  - A granted buffer can be refilled in the same cycle.
- Accept: on a handshake, the buffer loads Reg/Data and sets Valid.
  - Hold_Age is set to 1 if the other buffer is already valid and not being granted this cycle; otherwise 0.
- Arbitration (combinational, evaluated on buffer contents):
  - Only one valid: grant it.
  - Both valid, one has Hold_Age=0 (older): grant the older.
  - Both valid, equal age, same Hold_Reg: grant A first. B holds the later value and must land last.
  - Both valid, equal age, different Hold_Reg: grant per RR_Ptr. RR_Ptr then flips to the other port.
- Granted buffer: Valid clears (unless refilled in the same cycle). The surviving buffer's Hold_Age clears to 0.
- Write stage:
  - On a grant, next edge RegWrite<=1, Write_Reg_Num<=Hold_Reg, Write_Data<=Hold_Data.
  - With no grant, RegWrite<=0. Write_Reg_Num/Write_Data hold their previous values.
- Exactly one register-file write per cycle at most. No write is ever dropped or duplicated.
- Writes to the same register commit in acceptance order. For same-cycle acceptance, A commits before B.
- Busy_Mask (combinational from registered state): OR of the one-hot of HoldA_Reg if HoldA_Valid, HoldB_Reg if HoldB_Valid, and Write_Reg_Num if RegWrite.
- All registers 0..7 are writable. Register 0 is not special.

## Timing
- Latency: handshake in cycle t, buffer valid in t+1, grant in t+1 (if won), RegWrite high in cycle t+2.
- Uncontended throughput: one write per cycle per port. Combined throughput: one write per cycle.
- Contended: a loser waits exactly one extra cycle. The worst-case wait from buffer-valid to grant is 1 cycle.
- Reset (synchronous, at the edge with Reset=1):
  - Hold_Valid(A,B)=0, Hold_Age=0, RR_Ptr=0.
  - RegWrite=0, Write_Reg_Num=0, Write_Data=0.
  - Busy_Mask=0 from the next cycle.
  - A_Ready=B_Ready=0 while Reset is high; both are 1 in the first cycle after Reset falls.
- Reset mid-operation: buffered and in-flight writes are discarded. A RegWrite pulse already on the outputs completes in its cycle. No write issues after the reset edge.
- Simultaneous accept on both ports with both buffers empty: both Age=0, tie rules apply.
- Back-pressure: while a buffer is valid and not granted, its Ready is 0. The requester must hold Valid/Reg/Data stable.

## Test plan
- Reset then single write: A_Valid=1, A_Reg_Num=3, A_Data=0x5A for one cycle.
  - Expect A_Ready=1, Busy_Mask=0x08 from t+1.
  - Expect RegWrite=1, Write_Reg_Num=3, Write_Data=0x5A in t+2 only, then Busy_Mask=0x00.
- Same-register tie: A (r5, 0x11) and B (r5, 0x22) in the same cycle.
  - Expect writes 0x11 at t+2, then 0x22 at t+3.
  - Expect B_Ready=0 in t+1 and Busy_Mask=0x20 through t+3.
- Round-robin: both ports stream different registers every cycle for 6 cycles.
  - Expect alternating A,B,A,B grants starting with A.
  - Expect every value written exactly once, in per-port order.
- Age priority: B (r2) is accepted one cycle before A (r4), and A wins the RR_Ptr.
  - Expect B's write first, then A's.
- Refill: A streams r1..r4 back-to-back with B idle.
  - Expect A_Ready held at 1 and RegWrite high four consecutive cycles.
- Reset mid-operation: assert Reset with both buffers full.
  - Expect no RegWrite after the reset edge, Busy_Mask=0, Ready=0 during reset and 1 after.
